// File: rtl/sm83_pkg.sv
// Shared SM83 core definitions: opcode constants, interrupt-dispatch length
// and the fetch-stage state encoding.
package sm83_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_CB  = 8'hCB;

    localparam int INT_MCYCLES_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PREFIX = 2'd1,
        INTSEQ = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mcycle_counter.sv
// 3-bit saturating up-counter; clr takes priority over inc.
module mcycle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else if (inc && count != 3'd7) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/opcode_fetch.sv
// Instruction register and fetch control: latches opcodes at FetchEnd, tracks the
// CB prefix, substitutes the interrupt-dispatch pseudo-op and counts M-cycles.
module opcode_fetch
    import sm83_pkg::*;
#(
    parameter int INT_MCYCLES = INT_MCYCLES_DEFAULT
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic [7:0]   DataBus,
    input  logic         FetchEnd,
    input  logic         NextM,
    input  logic         IntReq,
    output logic [7:0]   IR,
    output logic         CB,
    output logic         IntAck,
    output logic         IR_Valid,
    output logic [2:0]   MCycle,
    output fetch_state_t dbg_state
);

    fetch_state_t state_q, state_d;
    logic [7:0]   ir_d;
    logic         cb_d;
    logic         ack_d;
    logic [2:0]   int_cnt;

    assign dbg_state = state_q;

    // An early FetchEnd in INTSEQ is handled exactly like a RUN fetch, so only
    // PREFIX needs its own branch.
    always_comb begin
        state_d = state_q;
        ir_d    = IR;
        cb_d    = CB;
        ack_d   = IntAck;
        if (FetchEnd) begin
            if (state_q == PREFIX) begin
                ir_d    = DataBus;
                cb_d    = 1'b1;
                ack_d   = 1'b0;
                state_d = RUN;
            end else if (IntReq) begin
                ir_d    = OP_NOP;
                cb_d    = 1'b0;
                ack_d   = 1'b1;
                state_d = INTSEQ;
            end else begin
                ir_d    = DataBus;
                cb_d    = 1'b0;
                ack_d   = 1'b0;
                state_d = (DataBus == OP_CB) ? PREFIX : RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= RUN;
            IR       <= OP_NOP;
            CB       <= 1'b0;
            IntAck   <= 1'b0;
            IR_Valid <= 1'b0;
        end else begin
            state_q <= state_d;
            IR      <= ir_d;
            CB      <= cb_d;
            IntAck  <= ack_d;
            if (FetchEnd) begin
                IR_Valid <= 1'b1;
            end
        end
    end

    mcycle_counter u_mcycle (
        .clk   (CLK),
        .rst_n (nRESET),
        .clr   (FetchEnd),
        .inc   (NextM),
        .count (MCycle)
    );

    // Every FetchEnd clears the dispatch count, which also zeroes it on INTSEQ entry.
    mcycle_counter u_int_cnt (
        .clk   (CLK),
        .rst_n (nRESET),
        .clr   (FetchEnd),
        .inc   (NextM && state_q == INTSEQ),
        .count (int_cnt)
    );

    a_no_early_fetch_in_intseq : assert property (
        @(posedge CLK) disable iff (!nRESET)
        !(FetchEnd && state_q == INTSEQ && int_cnt != 3'(INT_MCYCLES - 1))
    );

endmodule

// File: doc/opcode_fetch.md
# opcode_fetch

Instruction-register and fetch-control stage directly upstream of the Sequencer. It captures the opcode byte from the internal data bus at the end of each fetch M-cycle and drives the Sequencer's `IR[7:0]` input. It also tracks the 0xCB prefix, substitutes the interrupt-dispatch pseudo-instruction when an interrupt is pending, and keeps the M-cycle index of the current instruction for the decoder.

## Interface
- `INT_MCYCLES`, default 5: number of M-cycles in the interrupt-dispatch pseudo-instruction.
- `CLK  in  1`: single clock, rising edge.
- `nRESET  in  1`: asynchronous, active-low reset.
- `DataBus  in  8`: internal data bus. The opcode byte is valid here when `FetchEnd`=1.
- `FetchEnd  in  1`: one-CLK pulse marking the last cycle of an opcode-fetch M-cycle.
- `NextM  in  1`: one-CLK pulse marking the end of any non-fetch M-cycle.
- `IntReq  in  1`: interrupt pending and IME set. Sampled only at `FetchEnd`.
- `IR  out  8`: opcode to the Sequencer/decoder.
- `CB  out  1`: the current `IR` is a CB-page opcode.
- `IntAck  out  1`: an interrupt-dispatch pseudo-instruction is in progress.
- `IR_Valid  out  1`: `IR` holds a fetched opcode (0 until the first fetch after reset).
- `MCycle  out  3`: M-cycle index within the current instruction.

## Operation
- **Reset values.** `IR`=8'h00, `CB`=0, `IntAck`=0, `IR_Valid`=0, `MCycle`=0, state=RUN, `int_cnt`=0.
- **States.** RUN, PREFIX, INTSEQ.
- **RUN + `FetchEnd`, `IntReq`=1.**
  - `IR`<=8'h00, `IntAck`<=1, `CB`<=0, `int_cnt`<=0, go to INTSEQ.
  - `DataBus` is discarded.
- **RUN + `FetchEnd`, `IntReq`=0.**
  - `IR`<=`DataBus`, `CB`<=0.
  - If `DataBus`==8'hCB, go to PREFIX; otherwise stay in RUN.
- **PREFIX + `FetchEnd`.**
  - `IR`<=`DataBus`, `CB`<=1, go to RUN.
  - `IntReq` is ignored: no interrupt is taken between the prefix and its opcode.
  - `DataBus`==8'hCB here is an ordinary CB-page opcode (SET 1,E). It does not re-enter PREFIX.
- **INTSEQ.**
  - Each `NextM` increments `int_cnt`.
  - On the `NextM` that brings `int_cnt` to `INT_MCYCLES`-1, `IntAck` stays 1 through that cycle. It clears on the following `FetchEnd`, which is handled as in RUN (go to RUN or INTSEQ).
  - A `FetchEnd` in INTSEQ before the count completes is a protocol error. The block treats it as a RUN fetch; an assertion fires in simulation.
- **`IR_Valid`.** Set to 1 by the first `FetchEnd` after reset; stays 1 until reset.
- **`MCycle`.**
  - Cleared to 0 by any `FetchEnd`.
  - Incremented by `NextM`; saturates at 7 with no wrap.
- **Simultaneous `FetchEnd` and `NextM`.** `FetchEnd` wins: `MCycle`=0 and `int_cnt` is not incremented.
- **Reset mid-instruction.** All state returns to reset values immediately. The prefix and an interrupt in progress are abandoned.

## Timing
- `IR`, `CB`, `IntAck`, `IR_Valid` and `MCycle` are registered. They update on the CLK edge at which `FetchEnd`/`NextM` is sampled high and are visible the cycle after.
- Latency from `DataBus` to `IR`: 1 CLK.
- All outputs are glitch-free; no combinational path from input to output.
- `nRESET` assertion is asynchronous. Deassertion must be synchronized externally to CLK.

## Structure
- Shared package `sm83_pkg`:
  - `OP_NOP`=8'h00, `OP_CB`=8'hCB.
  - `INT_MCYCLES` default.
  - Enum `fetch_state_t` {RUN, PREFIX, INTSEQ}.
- Sub-module `mcycle_counter`:
  - 3-bit saturating counter with `clr` (priority) and `inc` inputs.
  - Instantiated for `MCycle`; also reused for `int_cnt`.

## Test plan
- Reset, then `DataBus`=8'h3E with `FetchEnd` -> next cycle `IR`=8'h3E, `CB`=0, `IR_Valid`=1, `MCycle`=0.
- Fetch 8'hCB then fetch 8'h37 -> after the first fetch `IR`=8'hCB, `CB`=0; after the second `IR`=8'h37, `CB`=1; the next plain fetch of 8'h00 gives `CB`=0.
- `IntReq`=1 at a RUN `FetchEnd` with `DataBus`=8'h76 -> `IR`=8'h00, `IntAck`=1. Four `NextM` pulses give `MCycle`=4; the next `FetchEnd` clears `IntAck`.
- `IntReq`=1 during a PREFIX `FetchEnd` with 8'hCB on the bus -> `IR`=8'hCB, `CB`=1, `IntAck`=0.
- Eight `NextM` pulses without `FetchEnd` -> `MCycle` stops at 7. `FetchEnd` coincident with `NextM` -> `MCycle`=0.
- `nRESET` low mid-INTSEQ with `MCycle`=2 -> all outputs return to reset values within the same cycle, asynchronously.
